// File: rtl/lm70_pkg.sv
// Shared constants, types and helpers for the LM70-style temperature sensor model.
// Frame is 16 bits read then 16 bits written; the bit counter saturates at 32.
package lm70_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned IDX_W      = $clog2(FRAME_BITS);

  typedef logic [FRAME_BITS-1:0] word_t;

  localparam word_t LM70_ID_WORD = 16'h800F;
  localparam word_t CMD_SHUTDOWN = 16'hFFFF;
  localparam word_t CMD_NORMAL   = 16'h0000;

  typedef enum logic [1:0] {
    PH_READ,
    PH_WRITE,
    PH_DONE
  } phase_e;

  // Whole degrees to register image; arithmetic shift keeps negative values correct.
  function automatic word_t temp_to_word(input byte deg_c);
    return $signed({deg_c, 8'h00}) >>> 1;
  endfunction

endpackage

// File: rtl/lm70_temp_sensor_if.sv
// Host-side control bus of the sensor: chip select and the static temperature word.
// No handshake; the host owns both signals and the sensor only observes them.
interface lm70_temp_sensor_if;
  import lm70_pkg::*;

  logic  CS;
  word_t TEMP_SET;

  modport master (output CS, output TEMP_SET);
  modport slave  (input CS, input TEMP_SET);

endinterface

// File: rtl/lm70_shift_engine.sv
// Bit counter, read-side bit mux and write-side command shift register.
// Latency: read bit is combinational from the counter; no backpressure, paced by SCK only.
module lm70_shift_engine
  import lm70_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  cs_n,
  input  word_t frame,
  input  logic  sio_in,
  output logic  sio_out,
  output logic  sio_oe,
  output logic  cmd_vld,
  output word_t cmd_dat
);

  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  word_t            cmd_q, cmd_d;
  phase_e           phase;
  logic             sio_bit;

  always_comb begin
    phase = PH_DONE;
    if (bit_cnt_q < CNT_W'(FRAME_BITS)) begin
      phase = PH_READ;
    end else if (bit_cnt_q < CNT_W'(2 * FRAME_BITS)) begin
      phase = PH_WRITE;
    end
  end

  // A floating or unknown line from the host is taken as a 0.
  assign sio_bit = (sio_in === 1'b1);

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd_q;
    cmd_vld   = 1'b0;
    if (!rst_n) begin
      bit_cnt_d = '0;
      cmd_d     = '0;
    end else if (cs_n) begin
      bit_cnt_d = '0;
    end else begin
      case (phase)
        PH_READ: begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        PH_WRITE: begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          cmd_d     = {cmd_q[FRAME_BITS-2:0], sio_bit};
          cmd_vld   = (bit_cnt_q == CNT_W'(2 * FRAME_BITS - 1));
        end
        default: begin
          bit_cnt_d = bit_cnt_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    bit_cnt_q <= bit_cnt_d;
    cmd_q     <= cmd_d;
  end

  assign cmd_dat = cmd_d;
  assign sio_out = frame[IDX_W'(FRAME_BITS - 1) - bit_cnt_q[IDX_W-1:0]];
  assign sio_oe  = rst_n && !cs_n && (phase == PH_READ);

endmodule

// File: rtl/lm70_temp_sensor.sv
// LM70-style SPI temperature sensor: returns a 16-bit frame MSB first, then takes a 16-bit command.
// Latency: D15 is on SIO as soon as CS falls; no backpressure, the host paces everything with SCK.
module lm70_temp_sensor
  import lm70_pkg::*;
#(
  parameter word_t ID_WORD = LM70_ID_WORD
) (
  input  logic               SCK,
  input  logic               RSTN,
  lm70_temp_sensor_if.slave  bus,
  inout  wire                SIO
);

  word_t frame_q, frame_d;
  logic  shutdown_q, shutdown_d;
  logic  sio_out;
  logic  sio_oe;
  logic  cmd_vld;
  word_t cmd_dat;
  logic  temp_lsb_unused;

  assign temp_lsb_unused = ^bus.TEMP_SET[4:0];

  lm70_shift_engine u_shift (
    .clk     (SCK),
    .rst_n   (RSTN),
    .cs_n    (bus.CS),
    .frame   (frame_q),
    .sio_in  (SIO),
    .sio_out (sio_out),
    .sio_oe  (sio_oe),
    .cmd_vld (cmd_vld),
    .cmd_dat (cmd_dat)
  );

  // The frame is only reloaded while deselected, so TEMP_SET edits never tear a frame.
  always_comb begin
    frame_d    = frame_q;
    shutdown_d = shutdown_q;
    if (!RSTN) begin
      frame_d    = '0;
      shutdown_d = 1'b0;
    end else if (bus.CS) begin
      frame_d = shutdown_q ? ID_WORD : {bus.TEMP_SET[15:5], 3'b111, 2'b00};
    end else if (cmd_vld) begin
      if (cmd_dat == CMD_SHUTDOWN) begin
        shutdown_d = 1'b1;
      end else if (cmd_dat == CMD_NORMAL) begin
        shutdown_d = 1'b0;
      end
    end
  end

  always_ff @(posedge SCK) begin
    frame_q    <= frame_d;
    shutdown_q <= shutdown_d;
  end

  assign SIO = sio_oe ? sio_out : 1'bz;

endmodule

// File: tb/tb_lm70_temp_sensor.sv
// Bench for lm70_temp_sensor: table of full frames plus hand-written reset/abort sequences.
// Read words are queued as expectations when a frame starts and compared when the frame ends.
module tb_lm70_temp_sensor;
  import lm70_pkg::*;

  typedef struct {
    word_t temp;
    word_t mid;
    word_t cmd;
    word_t exp_word;
    logic  exp_sd;
  } vec_t;

  logic  sck = 1'b0;
  logic  rstn;
  logic  host_en;
  logic  host_bit;
  wire   sio;
  int    n_vec = 0;
  int    n_err = 0;
  word_t exp_q[$];
  vec_t  vecs[10];
  word_t rd;

  lm70_temp_sensor_if bus();

  lm70_temp_sensor dut (
    .SCK  (sck),
    .RSTN (rstn),
    .bus  (bus),
    .SIO  (sio)
  );

  assign sio = host_en ? host_bit : 1'bz;

  always #10 sck = ~sck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called right after a falling SCK edge; one idle edge, then nbits rising edges with CS low.
  task automatic do_frame(input word_t temp, input word_t mid, input word_t cmd,
                          input int nbits, input bit hold_cs, output word_t rd_word);
    bus.TEMP_SET = temp;
    bus.CS       = 1'b1;
    host_en      = 1'b0;
    @(negedge sck);
    bus.CS  = 1'b0;
    rd_word = '0;
    for (int k = 0; k < nbits; k++) begin
      if (k == 8) bus.TEMP_SET = mid;
      if (k < 16) begin
        #1;
        rd_word[4'(15 - k)] = sio;
        if (nbits >= 34 && k == 0) check("d15_driven", 16'(dut.sio_oe), 16'd1);
      end else if (k < 32) begin
        host_bit = cmd[4'(31 - k)];
        host_en  = 1'b1;
      end else begin
        host_en = 1'b0;
      end
      if (nbits >= 34 && k == 16) begin
        #1;
        check("wr_phase_z", 16'(dut.sio_oe), 16'd0);
      end
      if (nbits >= 34 && k == 33) begin
        #1;
        check("overrun_z", 16'(dut.sio_oe), 16'd0);
      end
      @(negedge sck);
    end
    host_en = 1'b0;
    if (!hold_cs) bus.CS = 1'b1;
  endtask

  initial begin
    vecs[0] = '{16'h0C00, 16'h7FE0, 16'h0000, 16'h0C1C, 1'b0};
    vecs[1] = '{16'hFC80, 16'h0C00, 16'h0000, 16'hFC9C, 1'b0};
    vecs[2] = '{temp_to_word(8'sd25), temp_to_word(-8'sd7), 16'hFFFF, 16'h0C9C, 1'b1};
    vecs[3] = '{16'h0C00, 16'h0C00, 16'h1234, 16'h800F, 1'b1};
    vecs[4] = '{16'h0C00, 16'hFC80, 16'h0000, 16'h800F, 1'b0};
    vecs[5] = '{16'hFC80, 16'hFC80, 16'h0000, 16'hFC9C, 1'b0};
    vecs[6] = '{16'h7FE0, 16'h8000, 16'h5555, 16'h7FFC, 1'b0};
    vecs[7] = '{16'h8000, 16'h0C00, 16'hFFFF, 16'h801C, 1'b1};
    vecs[8] = '{16'h001F, 16'h001F, 16'h0000, 16'h800F, 1'b0};
    vecs[9] = '{16'h001F, 16'h7FE0, 16'h0000, 16'h001C, 1'b0};

    rstn         = 1'b0;
    bus.CS       = 1'b1;
    bus.TEMP_SET = 16'h0C00;
    host_en      = 1'b0;
    host_bit     = 1'b0;

    // Held in reset: line must stay released whatever CS does.
    for (int i = 0; i < 6; i++) begin
      @(negedge sck);
      bus.CS = i[0];
      #1;
      check("reset_z", 16'(dut.sio_oe), 16'd0);
    end
    check("reset_shutdown", 16'(dut.shutdown_q), 16'd0);

    @(negedge sck);
    bus.CS = 1'b1;
    rstn   = 1'b1;

    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(vecs[i].exp_word);
      do_frame(vecs[i].temp, vecs[i].mid, vecs[i].cmd, 34, 1'b0, rd);
      check("read_word", rd, exp_q.pop_front());
      check("shutdown", 16'(dut.shutdown_q), 16'(vecs[i].exp_sd));
    end

    // Abort after 8 read bits, then a full frame must restart at D15.
    do_frame(16'h0C00, 16'h0C00, 16'h0000, 8, 1'b0, rd);
    check("partial_bits", 16'(rd[15:8]), 16'h000C);
    exp_q.push_back(16'h0C1C);
    do_frame(16'h0C00, 16'h0C00, 16'hFFFF, 34, 1'b0, rd);
    check("restart_word", rd, exp_q.pop_front());
    check("shutdown_set", 16'(dut.shutdown_q), 16'd1);

    // Abort one bit short of a full normal command: shutdown must survive.
    do_frame(16'h0C00, 16'h0C00, 16'h0000, 31, 1'b0, rd);
    check("abort_write_sd", 16'(dut.shutdown_q), 16'd1);

    // Reset in the middle of the write phase with CS still low.
    do_frame(16'h0C00, 16'h0C00, 16'h0000, 20, 1'b1, rd);
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sck);
      #1;
      check("reset_wr_z", 16'(dut.sio_oe), 16'd0);
    end
    check("reset_wr_sd", 16'(dut.shutdown_q), 16'd0);
    bus.CS = 1'b1;
    @(negedge sck);
    rstn = 1'b1;
    exp_q.push_back(16'h0C1C);
    do_frame(16'h0C00, 16'hFC80, 16'h1234, 34, 1'b0, rd);
    check("post_reset_word", rd, exp_q.pop_front());
    check("post_reset_sd", 16'(dut.shutdown_q), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
